// File: rtl/phase_accumulator_osc.sv
// Phase-accumulator oscillator: 16-bit phase, gated note FSM, waveform shaper.
// Optional HARD_SYNC_EN adds sync_in for hard oscillator sync.
module phase_accumulator_osc #(
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               freq_valid,
    output logic               freq_ready,
    input  logic [1:0]         wave_sel,
    input  logic               gate,
`ifdef HARD_SYNC_EN
    input  logic               sync_in,
`endif
    output logic [PHASE_W-1:0] sample,
    output logic               sample_valid,
    output logic               wrap
);
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);

    state_t state, state_nxt;
    logic [CW-1:0] div_cnt;
    logic tick;
    logic [PHASE_W-1:0] phase, active_freq, pend, nxt;
    logic pend_full, carry, sync_hit;
    logic [PHASE_W-1:0] phase_d, sample_d;
    logic wrap_d;

    function automatic logic [15:0] shape(input logic [1:0] sel,
                                          input logic [15:0] p);
        logic [15:0] t;
        t = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
        unique case (sel)
            2'b00:   shape = {~p[15], p[14:0]};
            2'b01:   shape = p[15] ? 16'h8001 : 16'h7FFF;
            2'b10:   shape = t ^ 16'h8000;
            default: shape = 16'h0000;
        endcase
    endfunction

    assign tick = (div_cnt == DIV_LAST);
    assign {carry, nxt} = {1'b0, phase} + {1'b0, active_freq};
    assign freq_ready = !pend_full;

`ifdef HARD_SYNC_EN
    logic sync_r, sync_d, sync_req;

    // Request survives until the next tick consumes it, whatever the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r   <= 1'b0;
            sync_d   <= 1'b0;
            sync_req <= 1'b0;
        end else begin
            sync_r   <= sync_in;
            sync_d   <= sync_r;
            sync_req <= (sync_r & ~sync_d) | (sync_req & ~tick);
        end
    end

    assign sync_hit = sync_req;
`else
    assign sync_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        phase_d   = phase;
        sample_d  = '0;
        wrap_d    = 1'b0;
        unique case (state)
            IDLE: begin
                phase_d = '0;
                if (gate) state_nxt = RUN;
            end
            RUN: begin
                phase_d  = sync_hit ? '0 : nxt;
                wrap_d   = carry & ~sync_hit;
                sample_d = shape(wave_sel, phase_d);
                if (!gate) state_nxt = RELEASE;
            end
            RELEASE: begin
                phase_d  = sync_hit ? '0 : nxt;
                wrap_d   = carry & ~sync_hit;
                sample_d = shape(wave_sel, phase_d);
                // A re-trigger wins over ending the note on the same tick.
                if (gate) begin
                    state_nxt = RUN;
                end else if (tick && wrap_d) begin
                    state_nxt = IDLE;
                    phase_d   = '0;
                    sample_d  = '0;
                end else if (tick && active_freq == '0) begin
                    state_nxt = IDLE;
                    phase_d   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            phase        <= '0;
            active_freq  <= '0;
            pend         <= '0;
            pend_full    <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            div_cnt      <= tick ? '0 : div_cnt + 1'b1;
            state        <= state_nxt;
            sample_valid <= tick;
            wrap         <= tick & wrap_d;
            if (tick) begin
                phase  <= phase_d;
                sample <= sample_d;
            end
            // A word accepted on a tick lands in pend and waits a full tick.
            if (freq_valid && freq_ready) begin
                pend      <= freq_word;
                pend_full <= 1'b1;
            end else if (tick && pend_full) begin
                pend_full <= 1'b0;
            end
            if (tick && pend_full) active_freq <= pend;
        end
    end
endmodule

// File: tb/tb_phase_accumulator_osc.sv
// Bench for phase_accumulator_osc: directed cases plus random run
// against a per-cycle arithmetic reference model.
module tb_phase_accumulator_osc;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] freq_word = '0;
    logic        freq_valid = 1'b0;
    logic        freq_ready;
    logic [1:0]  wave_sel = 2'b00;
    logic        gate = 1'b0;
    logic [15:0] sample;
    logic        sample_valid;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    // reference model state: 0 idle, 1 note held, 2 note released
    int m_cyc, m_st, m_phase, m_freq;
    int m_pq[$];
    int e_sample, e_valid, e_wrap;

    always #5 clk = ~clk;

    phase_accumulator_osc #(.PHASE_W(16), .SAMPLE_DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .freq_word(freq_word), .freq_valid(freq_valid),
        .freq_ready(freq_ready), .wave_sel(wave_sel), .gate(gate),
        .sample(sample), .sample_valid(sample_valid), .wrap(wrap)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wave(input int sel, input int p);
        int t;
        case (sel)
            0: wave = (p + 32768) % 65536;
            1: wave = (p >= 32768) ? 32'h8001 : 32'h7FFF;
            2: begin
                t = (p < 32768) ? 2 * p : 65535 - 2 * (p - 32768);
                wave = (t + 32768) % 65536;
            end
            default: wave = 0;
        endcase
    endfunction

    task automatic model_edge();
        bit tk, acc, cy;
        int sum, np;
        tk = (m_cyc % DIV) == DIV - 1;
        m_cyc++;
        acc = freq_valid && (m_pq.size() == 0);
        e_valid = tk;
        e_wrap = 0;
        if (tk) begin
            sum = m_phase + m_freq;
            np = sum % 65536;
            cy = sum > 65535;
            if (m_st == 0) begin
                e_sample = 0;
            end else begin
                e_sample = wave(int'(wave_sel), np);
                e_wrap = cy;
                m_phase = np;
                if (!gate && m_st == 2 && cy) begin
                    m_phase = 0;
                    e_sample = 0;
                    m_st = 0;
                end else if (!gate && m_st == 2 && m_freq == 0) begin
                    m_phase = 0;
                    m_st = 0;
                end
            end
            if (m_pq.size() > 0) m_freq = m_pq.pop_front();
        end
        if (acc) m_pq.push_back(int'(freq_word));
        if (m_st == 0 && gate) m_st = 1;
        else if (m_st == 1 && !gate) m_st = 2;
        else if (m_st == 2 && gate) m_st = 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check($sformatf("sample@%0d", m_cyc), sample, e_sample);
        check($sformatf("valid@%0d", m_cyc), sample_valid, e_valid);
        check($sformatf("wrap@%0d", m_cyc), wrap, e_wrap);
        check($sformatf("ready@%0d", m_cyc), freq_ready,
              (m_pq.size() == 0) ? 1 : 0);
    endtask

    task automatic tick_step(output logic [15:0] s, output logic w);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_valid && n < DIV + 1);
        check("tick_timeout", sample_valid, 1);
        s = sample;
        w = wrap;
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_wrap", wrap, 0);
        check("rst_ready", freq_ready, 1);
        m_cyc = 0; m_st = 0; m_phase = 0; m_freq = 0;
        m_pq.delete();
        e_sample = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Loads a word and waits until it is the active increment.
    task automatic load_freq(input logic [15:0] w);
        logic [15:0] s;
        logic        wr;
        tick_step(s, wr);
        freq_word = w;
        freq_valid = 1'b1;
        step();
        freq_valid = 1'b0;
        tick_step(s, wr);
    endtask

    initial begin
        logic [15:0] s;
        logic        w;
        logic [15:0] exp_saw [4];
        logic [15:0] exp_tri [4];
        logic [15:0] exp_sq [4];
        logic        r;
        bit          accepted;

        exp_saw = '{16'hC000, 16'h0000, 16'h4000, 16'h8000};
        exp_tri = '{16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
        exp_sq  = '{16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF};

        do_reset();
        for (int i = 0; i < 6; i++) step();

        load_freq(16'h4000);
        wave_sel = 2'b00;
        gate = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick_step(s, w);
            check($sformatf("saw%0d", i), s, exp_saw[i % 4]);
            check($sformatf("saw_wrap%0d", i), w, (i % 4 == 3) ? 1 : 0);
        end

        freq_word = 16'h1000;
        freq_valid = 1'b1;
        step();
        check("pend_full_ready", freq_ready, 0);
        freq_word = 16'h2000;
        accepted = 0;
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            r = freq_ready;
            step();
            if (r) begin
                accepted = 1;
                break;
            end
        end
        freq_valid = 1'b0;
        check("hs_accept", accepted, 1);
        for (int i = 0; i < 4 * DIV; i++) step();

        do_reset();
        load_freq(16'h4000);
        gate = 1'b1;
        tick_step(s, w);
        check("rel_s0", s, 16'hC000);
        tick_step(s, w);
        check("rel_s1", s, 16'h0000);
        gate = 1'b0;
        tick_step(s, w);
        check("rel_s2", s, 16'h4000);
        check("rel_w2", w, 0);
        tick_step(s, w);
        check("rel_s3", s, 16'h0000);
        check("rel_w3", w, 1);
        for (int i = 0; i < 4; i++) begin
            tick_step(s, w);
            check($sformatf("idle_s%0d", i), s, 0);
            check($sformatf("idle_w%0d", i), w, 0);
        end

        do_reset();
        load_freq(16'h4000);
        wave_sel = 2'b10;
        gate = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_step(s, w);
            check($sformatf("tri%0d", i), s, exp_tri[i]);
        end
        wave_sel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick_step(s, w);
            check($sformatf("sq%0d", i), s, exp_sq[i]);
        end

        do_reset();
        for (int i = 0; i < 16000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                freq_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0: freq_word = 16'h0000;
                    1: freq_word = 16'(($urandom_range(1, 15)) << 12);
                    default: freq_word = 16'($urandom);
                endcase
            end else begin
                freq_valid = 1'b0;
            end
            if ($urandom_range(0, 47) == 0) gate = ~gate;
            if ($urandom_range(0, 31) == 0) wave_sel = 2'($urandom);
            if (i == 9001) begin
                do_reset();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
